// File: rtl/spislave_tx_feeder.sv
// Byte feeder for the SPI slave shifter: queues outgoing MIDI bytes and loads one per
// slave-select frame. When nothing is queued, it loads IDLE_BYTE and counts an underrun.
module spislave_tx_feeder #(
    parameter int         DEPTH     = 16,
    parameter int         LD_CYCLES = 2,
    parameter logic [7:0] IDLE_BYTE = 8'hFD
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [7:0]             wr_data,
    input  logic                   wr_en,
    output logic                   wr_full,
    output logic [$clog2(DEPTH):0] fifo_level,
    input  logic                   ss,
    output logic [7:0]             data_o,
    output logic                   ld,
    output logic                   armed,
    output logic                   sent,
    output logic                   underrun,
    output logic [7:0]             underrun_cnt,
    output logic [1:0]             fsm_state
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(LD_CYCLES + 1);

    localparam logic [1:0] S_LOAD   = 2'd0;
    localparam logic [1:0] S_STAGED = 2'd1;
    localparam logic [1:0] S_IDLE   = 2'd2;
    localparam logic [1:0] S_BUSY   = 2'd3;

    logic          ss_m;
    logic          ss_s;
    logic          ss_d;
    logic          rise;

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    logic [AW:0]   level;
    logic [AW:0]   level_nxt;
    logic          push;
    logic          pop;
    logic          empty;
    logic [7:0]    head;

    logic [1:0]    state;
    logic          is_data;
    logic [CW-1:0] ld_cnt;

    // ss idles high, so the synchroniser resets high to avoid a false frame after reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            ss_m <= 1'b1;
            ss_s <= 1'b1;
            ss_d <= 1'b1;
        end else begin
            ss_m <= ss;
            ss_s <= ss_m;
            ss_d <= ss_s;
        end
    end

    assign rise  = ss_s & ~ss_d;
    assign empty = (level == '0);
    assign push  = wr_en & ~wr_full;
    assign head  = mem[rptr];

    always_comb begin
        pop = 1'b0;
        case (state)
            S_IDLE:  pop = ~empty & ss_s;
            S_BUSY:  pop = rise & ~empty;
            default: pop = 1'b0;
        endcase
    end

    always_comb begin
        level_nxt = level;
        if (push && !pop) begin
            level_nxt = level + 1'b1;
        end else if (!push && pop) begin
            level_nxt = level - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wptr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr    <= '0;
            rptr    <= '0;
            level   <= '0;
            wr_full <= 1'b0;
        end else begin
            if (push) begin
                wptr <= wptr + 1'b1;
            end
            if (pop) begin
                rptr <= rptr + 1'b1;
            end
            level   <= level_nxt;
            wr_full <= (level_nxt == (AW + 1)'(DEPTH));
        end
    end

    assign fifo_level = level;
    assign fsm_state  = state;

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= S_LOAD;
            is_data      <= 1'b0;
            data_o       <= IDLE_BYTE;
            ld           <= 1'b0;
            ld_cnt       <= '0;
            armed        <= 1'b0;
            sent         <= 1'b0;
            underrun     <= 1'b0;
            underrun_cnt <= 8'd0;
        end else begin
            sent     <= 1'b0;
            underrun <= 1'b0;
            case (state)
                S_LOAD: begin
                    // A frame starting mid-load is a host timing violation; abandon the strobe.
                    if (!ss_s) begin
                        ld    <= 1'b0;
                        state <= S_BUSY;
                    end else if (ld_cnt == CW'(LD_CYCLES)) begin
                        ld    <= 1'b0;
                        armed <= is_data;
                        state <= is_data ? S_STAGED : S_IDLE;
                    end else begin
                        ld     <= 1'b1;
                        ld_cnt <= ld_cnt + 1'b1;
                    end
                end
                S_IDLE: begin
                    if (!ss_s) begin
                        is_data <= 1'b0;
                        state   <= S_BUSY;
                    end else if (!empty) begin
                        data_o  <= head;
                        is_data <= 1'b1;
                        ld_cnt  <= '0;
                        state   <= S_LOAD;
                    end
                end
                S_STAGED: begin
                    if (!ss_s) begin
                        armed <= 1'b0;
                        state <= S_BUSY;
                    end
                end
                S_BUSY: begin
                    if (rise) begin
                        if (is_data) begin
                            sent <= 1'b1;
                        end else begin
                            underrun <= 1'b1;
                            if (underrun_cnt != 8'hFF) begin
                                underrun_cnt <= underrun_cnt + 8'd1;
                            end
                        end
                        if (!empty) begin
                            data_o  <= head;
                            is_data <= 1'b1;
                        end else begin
                            data_o  <= IDLE_BYTE;
                            is_data <= 1'b0;
                        end
                        ld_cnt <= '0;
                        state  <= S_LOAD;
                    end
                end
                default: begin
                    ld     <= 1'b0;
                    ld_cnt <= '0;
                    state  <= S_LOAD;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spislave_tx_feeder.sv
// Directed bench for spislave_tx_feeder: frame vectors from a table, plus hand-timed
// sequences for load latency, write/pop overlap, early frame start, saturation and reset.
module tb_spislave_tx_feeder;

    localparam int         DEPTH     = 16;
    localparam int         LD_CYCLES = 2;
    localparam logic [7:0] IDLE_BYTE = 8'hFD;

    localparam logic [1:0] ST_LOAD   = 2'd0;
    localparam logic [1:0] ST_STAGED = 2'd1;
    localparam logic [1:0] ST_IDLE   = 2'd2;
    localparam logic [1:0] ST_BUSY   = 2'd3;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] wr_data;
    logic       wr_en;
    logic       wr_full;
    logic [4:0] fifo_level;
    logic       ss;
    logic [7:0] data_o;
    logic       ld;
    logic       armed;
    logic       sent;
    logic       underrun;
    logic [7:0] underrun_cnt;
    logic [1:0] fsm_state;

    int checks   = 0;
    int failures = 0;
    logic [7:0] exp_q[$];

    typedef struct {
        logic [7:0] exp_byte;
        logic       exp_armed;
        logic       exp_sent;
        logic       exp_underrun;
        logic [7:0] exp_cnt;
    } frame_vec_t;

    frame_vec_t vecs[4];

    spislave_tx_feeder #(
        .DEPTH(DEPTH),
        .LD_CYCLES(LD_CYCLES),
        .IDLE_BYTE(IDLE_BYTE)
    ) dut (
        .clk(clk),
        .rst(rst),
        .wr_data(wr_data),
        .wr_en(wr_en),
        .wr_full(wr_full),
        .fifo_level(fifo_level),
        .ss(ss),
        .data_o(data_o),
        .ld(ld),
        .armed(armed),
        .sent(sent),
        .underrun(underrun),
        .underrun_cnt(underrun_cnt),
        .fsm_state(fsm_state)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: time limit reached, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic frame_start(output logic [7:0] byte_seen, output logic armed_seen);
        byte_seen  = data_o;
        armed_seen = armed;
        ss = 1'b0;
        repeat (4) tick();
    endtask

    task automatic frame_end(output int n_sent, output int n_und);
        n_sent = 0;
        n_und  = 0;
        ss = 1'b1;
        repeat (12) begin
            tick();
            if (sent) n_sent++;
            if (underrun) n_und++;
        end
    endtask

    task automatic do_frame(output logic [7:0] byte_seen, output logic armed_seen,
                            output int n_sent, output int n_und, output int n_ld);
        frame_start(byte_seen, armed_seen);
        n_ld = 0;
        repeat (4) begin
            tick();
            if (ld) n_ld++;
        end
        frame_end(n_sent, n_und);
    endtask

    task automatic count_reload(input string name);
        int n_ld;
        n_ld = 0;
        repeat (6) begin
            tick();
            if (ld) begin
                n_ld++;
                check({name, "_ld_data"}, data_o, IDLE_BYTE);
            end
        end
        check({name, "_ld_len"}, n_ld, LD_CYCLES);
    endtask

    initial begin
        logic [7:0] b;
        logic       a;
        int         ns;
        int         nu;
        int         nl;
        int         tot_und;

        vecs[0] = '{8'h90, 1'b1, 1'b1, 1'b0, 8'd0};
        vecs[1] = '{8'hFD, 1'b0, 1'b0, 1'b1, 8'd1};
        vecs[2] = '{8'hFD, 1'b0, 1'b0, 1'b1, 8'd2};
        vecs[3] = '{8'hFD, 1'b0, 1'b0, 1'b1, 8'd3};

        rst = 1'b1;
        ss = 1'b1;
        wr_en = 1'b0;
        wr_data = 8'h00;
        repeat (3) tick();

        // reset state
        check("rst_ld", ld, 0);
        check("rst_armed", armed, 0);
        check("rst_data", data_o, IDLE_BYTE);
        check("rst_sent", sent, 0);
        check("rst_underrun", underrun, 0);
        check("rst_cnt", underrun_cnt, 0);
        check("rst_full", wr_full, 0);
        check("rst_level", fifo_level, 0);
        check("rst_state", fsm_state, ST_LOAD);

        rst = 1'b0;
        count_reload("boot");
        check("boot_armed", armed, 0);
        check("boot_state", fsm_state, ST_IDLE);

        // single write: pop at N+1, ld at N+2..N+3, armed at N+4
        wr_en = 1'b1;
        wr_data = 8'h90;
        tick();
        wr_en = 1'b0;
        check("lat_level_n", fifo_level, 1);
        tick();
        check("lat_level_pop", fifo_level, 0);
        check("lat_data_pop", data_o, 8'h90);
        check("lat_ld_pop", ld, 0);
        tick();
        check("lat_ld_1", ld, 1);
        tick();
        check("lat_ld_2", ld, 1);
        check("lat_armed_early", armed, 0);
        tick();
        check("lat_ld_off", ld, 0);
        check("lat_armed", armed, 1);
        check("lat_state", fsm_state, ST_STAGED);

        for (int i = 0; i < 4; i++) begin
            do_frame(b, a, ns, nu, nl);
            check($sformatf("vec%0d_byte", i), b, vecs[i].exp_byte);
            check($sformatf("vec%0d_armed", i), a, vecs[i].exp_armed);
            check($sformatf("vec%0d_sent", i), ns, vecs[i].exp_sent);
            check($sformatf("vec%0d_underrun", i), nu, vecs[i].exp_underrun);
            check($sformatf("vec%0d_cnt", i), underrun_cnt, vecs[i].exp_cnt);
            check($sformatf("vec%0d_ld_in_frame", i), nl, 0);
        end

        // fill the FIFO while a frame holds the FSM in BUSY, then overflow by one
        frame_start(b, a);
        check("fill_state", fsm_state, ST_BUSY);
        for (int i = 0; i < 17; i++) begin
            wr_en = 1'b1;
            wr_data = (i < 16) ? 8'(i) : 8'hAA;
            tick();
            if (i < 16) exp_q.push_back(8'(i));
            if (i == 14) check("fill_full_early", wr_full, 0);
            if (i == 15) begin
                check("fill_full", wr_full, 1);
                check("fill_level", fifo_level, DEPTH);
            end
        end
        wr_en = 1'b0;
        check("ovf_full", wr_full, 1);
        check("ovf_level", fifo_level, DEPTH);
        frame_end(ns, nu);
        check("fill_frame_underrun", nu, 1);
        check("fill_frame_sent", ns, 0);
        check("fill_cnt", underrun_cnt, 4);
        check("fill_level_after", fifo_level, DEPTH - 1);
        check("fill_full_after", wr_full, 0);

        for (int k = 0; k < 16; k++) begin
            do_frame(b, a, ns, nu, nl);
            check($sformatf("burst%0d_byte", k), b, exp_q.pop_front());
            check($sformatf("burst%0d_sent", k), ns, 1);
            check($sformatf("burst%0d_underrun", k), nu, 0);
        end
        do_frame(b, a, ns, nu, nl);
        check("burst_end_byte", b, IDLE_BYTE);
        check("burst_end_underrun", nu, 1);
        check("burst_end_cnt", underrun_cnt, 5);

        // write coinciding with the end-of-frame pop
        frame_start(b, a);
        wr_en = 1'b1;
        wr_data = 8'hA1;
        tick();
        wr_data = 8'hA2;
        tick();
        wr_en = 1'b0;
        exp_q.push_back(8'hA1);
        exp_q.push_back(8'hA2);
        exp_q.push_back(8'hA3);
        check("ovl_level_before", fifo_level, 2);
        ss = 1'b1;
        tick();
        tick();
        wr_en = 1'b1;
        wr_data = 8'hA3;
        tick();
        wr_en = 1'b0;
        check("ovl_level", fifo_level, 2);
        check("ovl_data", data_o, 8'hA1);
        check("ovl_underrun", underrun, 1);
        repeat (10) tick();
        check("ovl_cnt", underrun_cnt, 6);
        for (int k = 0; k < 3; k++) begin
            do_frame(b, a, ns, nu, nl);
            check($sformatf("ovl%0d_byte", k), b, exp_q.pop_front());
            check($sformatf("ovl%0d_sent", k), ns, 1);
        end
        check("ovl_level_end", fifo_level, 0);

        // frame starts one cycle into a load
        wr_en = 1'b1;
        wr_data = 8'h5A;
        tick();
        wr_en = 1'b0;
        ss = 1'b0;
        tick();
        check("early_data", data_o, 8'h5A);
        check("early_ld_pop", ld, 0);
        tick();
        check("early_ld_on", ld, 1);
        tick();
        check("early_ld_drop", ld, 0);
        check("early_state", fsm_state, ST_BUSY);
        nl = 0;
        repeat (6) begin
            tick();
            if (ld) nl++;
        end
        check("early_ld_in_frame", nl, 0);
        frame_end(ns, nu);
        check("early_sent", ns, 1);
        check("early_underrun", nu, 0);
        check("early_cnt", underrun_cnt, 6);

        // underrun counter saturation
        tot_und = 0;
        for (int i = 0; i < 260; i++) begin
            do_frame(b, a, ns, nu, nl);
            tot_und += nu;
            if (i == 248) check("sat_reach", underrun_cnt, 255);
            if (i == 249) check("sat_hold", underrun_cnt, 255);
        end
        check("sat_pulses", tot_und, 260);
        check("sat_final", underrun_cnt, 255);

        // reset in the middle of a frame flushes everything
        frame_start(b, a);
        wr_en = 1'b1;
        wr_data = 8'h33;
        tick();
        wr_data = 8'h44;
        tick();
        wr_en = 1'b0;
        check("mid_level", fifo_level, 2);
        rst = 1'b1;
        tick();
        ss = 1'b1;
        tick();
        check("mid_rst_cnt", underrun_cnt, 0);
        check("mid_rst_level", fifo_level, 0);
        check("mid_rst_full", wr_full, 0);
        check("mid_rst_data", data_o, IDLE_BYTE);
        check("mid_rst_ld", ld, 0);
        check("mid_rst_armed", armed, 0);
        check("mid_rst_state", fsm_state, ST_LOAD);
        rst = 1'b0;
        count_reload("mid");
        check("mid_state", fsm_state, ST_IDLE);
        check("mid_level_after", fifo_level, 0);
        do_frame(b, a, ns, nu, nl);
        check("mid_frame_byte", b, IDLE_BYTE);
        check("mid_frame_underrun", nu, 1);
        check("mid_frame_sent", ns, 0);
        check("mid_frame_cnt", underrun_cnt, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
